control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 153 +++++++++++++++
 tb/tb_control_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit accumulator CPU: steps through fetch
// and per-opcode execute microsteps, producing the 16-bit active-high control word.
module control_sequencer #(
    parameter int N     = 8,
    parameter int OPW   = 4,
    parameter int STEPS = 5,
    parameter int EARLY = 1,
    parameter int SW    = 3
) (
    input  logic          clk,
    input  logic          clr_,
    input  logic          run,
    input  logic [N-1:0]  ir,
    input  logic          cf,
    input  logic          zf,
    output logic [15:0]   ctrl,
    output logic [SW-1:0] step,
    output logic          halted,
    output logic          last
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   step_nxt;
    logic [OPW-1:0]  opcode;
    logic [15:0]     ctrl_raw;
    int              len;
    logic            unused_ir;

    // Execute microword for execute step k (k = step - 2).
    function automatic logic [15:0] exec_word(input logic [OPW-1:0] op, input int k,
                                              input logic c, input logic z);
        logic [15:0] w;
        w = '0;
        case (op)
            OP_LDA: begin
                if (k == 0)      w = C_IO | C_MI;
                else if (k == 1) w = C_RO | C_AI;
            end
            OP_ADD, OP_SUB: begin
                if (k == 0)      w = C_IO | C_MI;
                else if (k == 1) w = C_RO | C_BI;
                else if (k == 2) w = C_EO | C_AI | C_FI | ((op == OP_SUB) ? C_SU : 16'h0000);
            end
            OP_STA: begin
                if (k == 0)      w = C_IO | C_MI;
                else if (k == 1) w = C_AO | C_RI;
            end
            OP_LDI: if (k == 0) w = C_IO | C_AI;
            OP_JMP: if (k == 0) w = C_IO | C_J;
            OP_JC:  if (k == 0 && c) w = C_IO | C_J;
            OP_JZ:  if (k == 0 && z) w = C_IO | C_J;
            OP_OUT: if (k == 0) w = C_AO | C_OI;
            OP_HLT: if (k == 0) w = C_HLT;
            default: w = '0;
        endcase
        return w;
    endfunction

    // Number of execute steps actually used; branches shrink to zero when not taken.
    function automatic int exec_len(input logic [OPW-1:0] op, input logic c, input logic z);
        int n;
        case (op)
            OP_LDA, OP_STA:                 n = 2;
            OP_ADD, OP_SUB:                 n = 3;
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: n = 1;
            OP_JC:                          n = c ? 1 : 0;
            OP_JZ:                          n = z ? 1 : 0;
            default:                        n = 0;
        endcase
        return n;
    endfunction

    assign unused_ir = ^ir;
    assign halted    = (state == S_HALT);

    always_comb begin
        opcode   = ir[N-1:N-OPW];
        len      = (EARLY != 0) ? 2 + exec_len(opcode, cf, zf) : STEPS;
        ctrl_raw = '0;
        if (state == S_HALT)
            ctrl_raw = C_HLT;
        else if (step == '0)
            ctrl_raw = C_CO | C_MI;
        else if (step == SW'(1))
            ctrl_raw = C_RO | C_II | C_CE;
        else
            ctrl_raw = exec_word(opcode, int'(step) - 2, cf, zf);
        last = (int'(step) == len - 1);
        // Reset blanks the control word immediately, without waiting for a clock.
        ctrl = clr_ ? ctrl_raw : 16'h0000;
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        if (int'(step) >= STEPS) begin
            step_nxt = '0;
        end else if (run && state == S_RUN) begin
            // HLT step: freeze the counter where it is and latch the halt.
            if (ctrl_raw[15])
                state_nxt = S_HALT;
            else if (last || int'(step) >= STEPS - 1)
                step_nxt = '0;
            else
                step_nxt = step + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state <= S_RUN;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-opcode microstep table plus hand-written
// sequences for halt, reset mid-instruction, run hold, flag changes and EARLY=0.
module tb_control_sequencer;

    logic        clk;
    logic        clr_;
    logic        run;
    logic        run2;
    logic [7:0]  ir;
    logic [7:0]  ir2;
    logic        cf;
    logic        zf;
    logic [15:0] ctrl;
    logic [15:0] ctrl2;
    logic [2:0]  step;
    logic [2:0]  step2;
    logic        halted;
    logic        halted2;
    logic        last;
    logic        last2;

    int checks   = 0;
    int failures = 0;

    control_sequencer dut (
        .clk(clk), .clr_(clr_), .run(run), .ir(ir), .cf(cf), .zf(zf),
        .ctrl(ctrl), .step(step), .halted(halted), .last(last)
    );

    control_sequencer #(.N(8), .OPW(4), .STEPS(6), .EARLY(0), .SW(3)) dut6 (
        .clk(clk), .clr_(clr_), .run(run2), .ir(ir2), .cf(cf), .zf(zf),
        .ctrl(ctrl2), .step(step2), .halted(halted2), .last(last2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  ir;
        logic        cf;
        logic        zf;
        int          len;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [7:0] i, input logic c, input logic z, input int n,
                                input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
        vec_t v;
        v.ir = i; v.cf = c; v.zf = z; v.len = n; v.e0 = a; v.e1 = b; v.e2 = d;
        return v;
    endfunction

    function automatic logic [15:0] exp_word(input vec_t v, input int s);
        case (s)
            0:       return 16'h4004;
            1:       return 16'h1408;
            2:       return v.e0;
            3:       return v.e1;
            4:       return v.e2;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr_ = 1'b0;
        #1;
        clr_ = 1'b1;
        #1;
    endtask

    initial begin
        clr_ = 1'b0; run = 1'b1; run2 = 1'b0;
        ir = 8'h2A; ir2 = 8'h00; cf = 1'b0; zf = 1'b0;

        tbl[0]  = mk(8'h00, 0, 0, 2, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(8'h1F, 0, 0, 4, 16'h4800, 16'h1200, 16'h0000);
        tbl[2]  = mk(8'h2A, 1, 1, 5, 16'h4800, 16'h1020, 16'h0281);
        tbl[3]  = mk(8'h3A, 0, 0, 5, 16'h4800, 16'h1020, 16'h02C1);
        tbl[4]  = mk(8'h4F, 0, 0, 4, 16'h4800, 16'h2100, 16'h0000);
        tbl[5]  = mk(8'h53, 0, 0, 3, 16'h0A00, 16'h0000, 16'h0000);
        tbl[6]  = mk(8'h61, 0, 0, 3, 16'h0802, 16'h0000, 16'h0000);
        tbl[7]  = mk(8'h70, 0, 1, 2, 16'h0000, 16'h0000, 16'h0000);
        tbl[8]  = mk(8'h75, 1, 0, 3, 16'h0802, 16'h0000, 16'h0000);
        tbl[9]  = mk(8'h80, 1, 0, 2, 16'h0000, 16'h0000, 16'h0000);
        tbl[10] = mk(8'h8C, 0, 1, 3, 16'h0802, 16'h0000, 16'h0000);
        tbl[11] = mk(8'hE0, 0, 0, 3, 16'h0110, 16'h0000, 16'h0000);
        tbl[12] = mk(8'h9F, 1, 1, 2, 16'h0000, 16'h0000, 16'h0000);
        tbl[13] = mk(8'hD0, 0, 0, 2, 16'h0000, 16'h0000, 16'h0000);

        // Reset held across a clock edge
        #12;
        chk("rst_step",   32'(step),   32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ctrl",   32'(ctrl),   32'h0000);
        chk("rst_last",   32'(last),   32'd0);
        clr_ = 1'b1;
        #1;
        chk("rst_release_ctrl", 32'(ctrl), 32'h4004);

        // Per-opcode microstep table
        for (int i = 0; i < 14; i++) begin
            tick();
            do_reset();
            ir = tbl[i].ir; cf = tbl[i].cf; zf = tbl[i].zf; run = 1'b1;
            #1;
            for (int s = 0; s < tbl[i].len; s++) begin
                chk($sformatf("v%0d_step%0d", i, s), 32'(step), 32'(s));
                chk($sformatf("v%0d_ctrl%0d", i, s), 32'(ctrl), 32'(exp_word(tbl[i], s)));
                chk($sformatf("v%0d_last%0d", i, s), 32'(last), (s == tbl[i].len - 1) ? 32'd1 : 32'd0);
                tick();
            end
            chk($sformatf("v%0d_wrap_step", i), 32'(step), 32'd0);
            chk($sformatf("v%0d_wrap_ctrl", i), 32'(ctrl), 32'h4004);
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
        end

        // HLT: halt, freeze, ignore opcode, clear only by reset
        do_reset();
        ir = 8'hF0; run = 1'b1;
        #1;
        chk("hlt_t0", 32'(ctrl), 32'h4004);
        tick();
        chk("hlt_t1", 32'(ctrl), 32'h1408);
        tick();
        chk("hlt_t2_ctrl", 32'(ctrl), 32'h8000);
        chk("hlt_t2_last", 32'(last), 32'd1);
        chk("hlt_t2_halted", 32'(halted), 32'd0);
        tick();
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_step", 32'(step), 32'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("hlt_freeze%0d", k), 32'(step), 32'd2);
        end
        ir = 8'h10;
        #1;
        chk("hlt_ctrl_other_op", 32'(ctrl), 32'h8000);
        tick();
        chk("hlt_still_halted", 32'(halted), 32'd1);
        chk("hlt_still_step", 32'(step), 32'd2);
        clr_ = 1'b0;
        #1;
        chk("hlt_clr_step", 32'(step), 32'd0);
        chk("hlt_clr_halted", 32'(halted), 32'd0);
        chk("hlt_clr_ctrl", 32'(ctrl), 32'h0000);
        clr_ = 1'b1;
        #1;
        chk("hlt_after_clr_ctrl", 32'(ctrl), 32'h4004);

        // HLT step with run=0 must not halt
        tick();
        do_reset();
        ir = 8'hF0; run = 1'b1;
        tick(); tick();
        run = 1'b0;
        tick();
        chk("hlt_run0_halted", 32'(halted), 32'd0);
        chk("hlt_run0_step", 32'(step), 32'd2);

        // Reset asserted mid-ADD at step 3
        do_reset();
        ir = 8'h2A; run = 1'b1;
        tick(); tick(); tick();
        chk("midadd_step", 32'(step), 32'd3);
        chk("midadd_ctrl", 32'(ctrl), 32'h1020);
        clr_ = 1'b0;
        #1;
        chk("midadd_clr_ctrl", 32'(ctrl), 32'h0000);
        chk("midadd_clr_step", 32'(step), 32'd0);
        clr_ = 1'b1;
        #1;
        chk("midadd_rel_ctrl", 32'(ctrl), 32'h4004);
        tick();
        chk("midadd_next_step", 32'(step), 32'd1);
        chk("midadd_next_ctrl", 32'(ctrl), 32'h1408);

        // run=0 for 3 cycles at step 2
        do_reset();
        ir = 8'h2A; run = 1'b1;
        tick(); tick();
        chk("hold_pre_ctrl", 32'(ctrl), 32'h4800);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_step%0d", k), 32'(step), 32'd2);
            chk($sformatf("hold_ctrl%0d", k), 32'(ctrl), 32'h4800);
        end
        run = 1'b1;
        tick();
        chk("hold_resume_step", 32'(step), 32'd3);
        chk("hold_resume_ctrl", 32'(ctrl), 32'h1020);

        // Carry changing during JC's T2 changes ctrl and last that cycle
        do_reset();
        ir = 8'h70; cf = 1'b1; zf = 1'b0; run = 1'b1;
        tick(); tick();
        chk("jcflag_taken_ctrl", 32'(ctrl), 32'h0802);
        chk("jcflag_taken_last", 32'(last), 32'd1);
        cf = 1'b0;
        #1;
        chk("jcflag_drop_ctrl", 32'(ctrl), 32'h0000);
        chk("jcflag_drop_last", 32'(last), 32'd0);
        cf = 1'b1;
        #1;
        chk("jcflag_back_ctrl", 32'(ctrl), 32'h0802);
        tick();
        chk("jcflag_wrap", 32'(step), 32'd0);

        // EARLY=0, STEPS=6 instance running LDI
        do_reset();
        ir2 = 8'h53; run2 = 1'b1; run = 1'b0;
        #1;
        for (int s = 0; s < 6; s++) begin
            chk($sformatf("e0_step%0d", s), 32'(step2), 32'(s));
            chk($sformatf("e0_ctrl%0d", s), 32'(ctrl2),
                (s == 0) ? 32'h4004 : (s == 1) ? 32'h1408 : (s == 2) ? 32'h0A00 : 32'h0000);
            chk($sformatf("e0_last%0d", s), 32'(last2), (s == 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk("e0_wrap", 32'(step2), 32'd0);
        chk("e0_halted", 32'(halted2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
